// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register-file write path.
package regfile_pkg;

    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 2 ** ADDR_W;
    localparam int unsigned DATA_W   = 32;

    // One-hot row select for a register address.
    function automatic logic [NUM_REGS-1:0] onehot_sel(input logic [ADDR_W-1:0] addr);
        return NUM_REGS'(1) << addr;
    endfunction

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Requester handshake plus registered regfile write port.
interface regfile_wr_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = regfile_pkg::DATA_W,
    parameter int unsigned ADDR_W  = regfile_pkg::ADDR_W
);

    localparam int unsigned SRC_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic                      wr_stall;
    logic                      wr_en;
    logic [ADDR_W-1:0]         wr_addr;
    logic [DATA_W-1:0]         wr_data;
    logic [NUM_REGS-1:0]       wr_sel;
    logic [SRC_W-1:0]          wr_src;

    // Requesters and regfile side together.
    modport master (
        output req_valid, req_addr, req_data, wr_stall,
        input  req_ready, wr_en, wr_addr, wr_data, wr_sel, wr_src
    );

    // The arbiter.
    modport slave (
        input  req_valid, req_addr, req_data, wr_stall,
        output req_ready, wr_en, wr_addr, wr_data, wr_sel, wr_src
    );

endinterface

// File: rtl/regfile_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    // Scan N candidates starting at ptr; the first valid one wins.
    always_comb begin
        logic [PTR_W-1:0] cand;
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = PTR_W'((32'(ptr) + i) % N);
            if (en && !any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
        if (any) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the regfile's single write port.
module regfile_wr_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_W      = regfile_pkg::DATA_W,
    parameter int unsigned ADDR_W      = regfile_pkg::ADDR_W,
    parameter bit          R0_READONLY = 1'b1
) (
    input logic                 clk,
    input logic                 rst_n,
    regfile_wr_arbiter_if.slave bus
);

    localparam int unsigned SRC_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned NUM_REGS = 2 ** ADDR_W;
    localparam int unsigned PKG_AW   = regfile_pkg::ADDR_W;

    logic [SRC_W-1:0]    rr_ptr_q,  rr_ptr_d;
    logic                wr_en_q,   wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [NUM_REGS-1:0] wr_sel_q,  wr_sel_d;
    logic [SRC_W-1:0]    wr_src_q,  wr_src_d;

    logic [NUM_REQ-1:0]  gnt;
    logic [SRC_W-1:0]    gnt_idx;
    logic                gnt_any;
    logic                pick_en;
    logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
    logic [DATA_W-1:0]   data_arr [NUM_REQ];
    logic [ADDR_W-1:0]   g_addr;
    logic [DATA_W-1:0]   g_data;

    // No grants while stalled or held in reset.
    assign pick_en = rst_n & ~bus.wr_stall;

    rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (SRC_W)
    ) u_pick (
        .req (bus.req_valid),
        .ptr (rr_ptr_q),
        .en  (pick_en),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    // Unpack requester payloads so only the granted entry is observed.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            addr_arr[i] = bus.req_addr[i*ADDR_W +: ADDR_W];
            data_arr[i] = bus.req_data[i*DATA_W +: DATA_W];
        end
    end

    assign g_addr = addr_arr[gnt_idx];
    assign g_data = data_arr[gnt_idx];

    // Next-state for the output register and round-robin pointer.
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        wr_en_d   = wr_en_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_sel_d  = wr_sel_q;
        wr_src_d  = wr_src_q;
        if (!bus.wr_stall) begin
            if (gnt_any) begin
                wr_addr_d = g_addr;
                wr_data_d = g_data;
                wr_src_d  = gnt_idx;
                wr_en_d   = !(R0_READONLY && (g_addr == '0));
                wr_sel_d  = wr_en_d ? NUM_REGS'(regfile_pkg::onehot_sel(PKG_AW'(g_addr))) : '0;
                rr_ptr_d  = (gnt_idx == SRC_W'(NUM_REQ - 1)) ? '0 : gnt_idx + SRC_W'(1);
            end else begin
                wr_en_d  = 1'b0;
                wr_sel_d = '0;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_sel_q  <= '0;
            wr_src_q  <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_sel_q  <= wr_sel_d;
            wr_src_q  <= wr_src_d;
        end
    end

    assign bus.req_ready = gnt;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.wr_sel    = wr_sel_q;
    assign bus.wr_src    = wr_src_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter with NUM_REQ=4.
module tb_regfile_wr_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    regfile_wr_arbiter_if #(.NUM_REQ(4), .DATA_W(32), .ADDR_W(5)) bus ();

    regfile_wr_arbiter #(
        .NUM_REQ     (4),
        .DATA_W      (32),
        .ADDR_W      (5),
        .R0_READONLY (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp, input bit ok);
        total++;
        if (!ok) begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
        bus.req_addr[i*5 +: 5]   = a;
        bus.req_data[i*32 +: 32] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0]  exp_src  [5];
        logic [4:0]  exp_addr [5];
        logic [31:0] exp_data [5];
        logic [31:0] exp_sel  [5];
        logic [3:0]  exp_rdy  [5];
        exp_src  = '{0, 1, 2, 3, 0};
        exp_addr = '{1, 2, 3, 4, 1};
        exp_data = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA0};
        exp_sel  = '{32'h2, 32'h4, 32'h8, 32'h10, 32'h2};
        exp_rdy  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

        // Reset with all requesters already valid.
        rst_n         = 1'b0;
        bus.wr_stall  = 1'b0;
        bus.req_valid = 4'hF;
        for (int i = 0; i < 4; i++) set_req(i, 5'(i + 1), 32'hA0 + 32'(i));
        #12;
        chk("rst_en",   64'(bus.wr_en),     64'(1'b0),    bus.wr_en === 1'b0);
        chk("rst_addr", 64'(bus.wr_addr),   64'(5'd0),    bus.wr_addr === 5'd0);
        chk("rst_data", 64'(bus.wr_data),   64'(32'd0),   bus.wr_data === 32'd0);
        chk("rst_sel",  64'(bus.wr_sel),    64'(32'd0),   bus.wr_sel === 32'd0);
        chk("rst_src",  64'(bus.wr_src),    64'(2'd0),    bus.wr_src === 2'd0);
        chk("rst_rdy",  64'(bus.req_ready), 64'(4'b0000), bus.req_ready === 4'b0000);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_rdy", 64'(bus.req_ready), 64'(4'b0001), bus.req_ready === 4'b0001);

        // All four valid: grants 0,1,2,3,0.
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_en",   64'(bus.wr_en),     64'(1'b1),        bus.wr_en === 1'b1);
            chk("rr_src",  64'(bus.wr_src),    64'(exp_src[k]),  5'(bus.wr_src) === exp_src[k]);
            chk("rr_addr", 64'(bus.wr_addr),   64'(exp_addr[k]), bus.wr_addr === exp_addr[k]);
            chk("rr_data", 64'(bus.wr_data),   64'(exp_data[k]), bus.wr_data === exp_data[k]);
            chk("rr_sel",  64'(bus.wr_sel),    64'(exp_sel[k]),  bus.wr_sel === exp_sel[k]);
            chk("rr_rdy",  64'(bus.req_ready), 64'(exp_rdy[k]),  bus.req_ready === exp_rdy[k]);
        end

        // Two stalled edges: output frozen on requester 0's write.
        bus.wr_stall = 1'b1;
        #1;
        chk("stl_rdy0", 64'(bus.req_ready), 64'(4'b0000), bus.req_ready === 4'b0000);
        repeat (2) begin
            tick();
            chk("stl_en",   64'(bus.wr_en),     64'(1'b1),    bus.wr_en === 1'b1);
            chk("stl_src",  64'(bus.wr_src),    64'(2'd0),    bus.wr_src === 2'd0);
            chk("stl_addr", 64'(bus.wr_addr),   64'(5'd1),    bus.wr_addr === 5'd1);
            chk("stl_sel",  64'(bus.wr_sel),    64'(32'h2),   bus.wr_sel === 32'h2);
            chk("stl_rdy",  64'(bus.req_ready), 64'(4'b0000), bus.req_ready === 4'b0000);
        end
        bus.wr_stall = 1'b0;
        #1;
        chk("unstl_rdy", 64'(bus.req_ready), 64'(4'b0010), bus.req_ready === 4'b0010);
        tick();
        chk("post_src1",  64'(bus.wr_src),  64'(2'd1),  bus.wr_src === 2'd1);
        chk("post_addr1", 64'(bus.wr_addr), 64'(5'd2),  bus.wr_addr === 5'd2);
        chk("post_sel1",  64'(bus.wr_sel),  64'(32'h4), bus.wr_sel === 32'h4);
        tick();
        chk("post_src2",  64'(bus.wr_src),  64'(2'd2),  bus.wr_src === 2'd2);
        chk("post_addr2", 64'(bus.wr_addr), 64'(5'd3),  bus.wr_addr === 5'd3);

        // Idle: wr_en drops, address/data/src hold.
        bus.req_valid = 4'h0;
        tick();
        chk("idle_en",   64'(bus.wr_en),     64'(1'b0),    bus.wr_en === 1'b0);
        chk("idle_sel",  64'(bus.wr_sel),    64'(32'h0),   bus.wr_sel === 32'h0);
        chk("idle_addr", 64'(bus.wr_addr),   64'(5'd3),    bus.wr_addr === 5'd3);
        chk("idle_data", 64'(bus.wr_data),   64'(32'hA2),  bus.wr_data === 32'hA2);
        chk("idle_src",  64'(bus.wr_src),    64'(2'd2),    bus.wr_src === 2'd2);
        chk("idle_rdy",  64'(bus.req_ready), 64'(4'b0000), bus.req_ready === 4'b0000);

        // Lone requester 2 at address 7, back to back.
        bus.req_valid = 4'b0100;
        set_req(2, 5'd7, 32'h77);
        #1;
        chk("lone_rdy0", 64'(bus.req_ready), 64'(4'b0100), bus.req_ready === 4'b0100);
        repeat (3) begin
            tick();
            chk("lone_en",   64'(bus.wr_en),     64'(1'b1),    bus.wr_en === 1'b1);
            chk("lone_addr", 64'(bus.wr_addr),   64'(5'd7),    bus.wr_addr === 5'd7);
            chk("lone_sel",  64'(bus.wr_sel),    64'(32'h80),  bus.wr_sel === 32'h80);
            chk("lone_src",  64'(bus.wr_src),    64'(2'd2),    bus.wr_src === 2'd2);
            chk("lone_data", 64'(bus.wr_data),   64'(32'h77),  bus.wr_data === 32'h77);
            chk("lone_rdy",  64'(bus.req_ready), 64'(4'b0100), bus.req_ready === 4'b0100);
        end
        // Pointer now at 3.
        bus.req_valid = 4'hF;
        #1;
        chk("ptr3_rdy", 64'(bus.req_ready), 64'(4'b1000), bus.req_ready === 4'b1000);
        tick();
        chk("ptr3_src",  64'(bus.wr_src),  64'(2'd3),   bus.wr_src === 2'd3);
        chk("ptr3_addr", 64'(bus.wr_addr), 64'(5'd4),   bus.wr_addr === 5'd4);
        chk("ptr3_sel",  64'(bus.wr_sel),  64'(32'h10), bus.wr_sel === 32'h10);

        // Requester 1 writes read-only register 0.
        bus.req_valid = 4'b0010;
        set_req(1, 5'd0, 32'hFFFF_FFFF);
        #1;
        chk("r0_rdy", 64'(bus.req_ready), 64'(4'b0010), bus.req_ready === 4'b0010);
        tick();
        chk("r0_en",   64'(bus.wr_en),   64'(1'b0),         bus.wr_en === 1'b0);
        chk("r0_sel",  64'(bus.wr_sel),  64'(32'h0),        bus.wr_sel === 32'h0);
        chk("r0_src",  64'(bus.wr_src),  64'(2'd1),         bus.wr_src === 2'd1);
        chk("r0_addr", 64'(bus.wr_addr), 64'(5'd0),         bus.wr_addr === 5'd0);
        chk("r0_data", 64'(bus.wr_data), 64'(32'hFFFF_FFFF), bus.wr_data === 32'hFFFF_FFFF);
        bus.req_valid = 4'hF;
        set_req(1, 5'd2, 32'hA1);
        #1;
        chk("r0_ptr_rdy", 64'(bus.req_ready), 64'(4'b0100), bus.req_ready === 4'b0100);

        // Reset mid-stream with a pending write.
        tick();
        chk("pre_rst_en",  64'(bus.wr_en),  64'(1'b1), bus.wr_en === 1'b1);
        chk("pre_rst_src", 64'(bus.wr_src), 64'(2'd2), bus.wr_src === 2'd2);
        rst_n = 1'b0;
        #1;
        chk("mrst_en",   64'(bus.wr_en),     64'(1'b0),    bus.wr_en === 1'b0);
        chk("mrst_addr", 64'(bus.wr_addr),   64'(5'd0),    bus.wr_addr === 5'd0);
        chk("mrst_data", 64'(bus.wr_data),   64'(32'd0),   bus.wr_data === 32'd0);
        chk("mrst_sel",  64'(bus.wr_sel),    64'(32'd0),   bus.wr_sel === 32'd0);
        chk("mrst_src",  64'(bus.wr_src),    64'(2'd0),    bus.wr_src === 2'd0);
        chk("mrst_rdy",  64'(bus.req_ready), 64'(4'b0000), bus.req_ready === 4'b0000);
        @(negedge clk);
        bus.req_valid = 4'b1001;
        rst_n = 1'b1;
        #1;
        chk("rrel_rdy", 64'(bus.req_ready), 64'(4'b0001), bus.req_ready === 4'b0001);
        tick();
        chk("rrel_src",  64'(bus.wr_src),  64'(2'd0),  bus.wr_src === 2'd0);
        chk("rrel_addr", 64'(bus.wr_addr), 64'(5'd1),  bus.wr_addr === 5'd1);
        chk("rrel_en",   64'(bus.wr_en),   64'(1'b1),  bus.wr_en === 1'b1);
        chk("rrel_sel",  64'(bus.wr_sel),  64'(32'h2), bus.wr_sel === 32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
